// File: rtl/memory_access.sv
// Memory-access pipeline stage: aligned loads/stores over a req/ack data bus,
// load byte-laning and extension, misaligned/illegal detection, registered write-back result.
module memory_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic [31:0]       i_ex_alu_result,
    input  logic [31:0]       i_ex_store_data,
    input  logic [4:0]        i_ex_rd_addr,
    input  logic              i_ex_rd_we,
    input  logic              i_ex_is_load,
    input  logic              i_ex_is_store,
    input  logic [2:0]        i_ex_funct3,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd_addr,
    output logic              o_wb_rd_we,
    output logic [31:0]       o_wb_rd_data,
    output logic              o_wb_exc,
    output logic [3:0]        o_wb_exc_cause,
    output logic [31:0]       o_wb_exc_tval
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t              r_state;
    logic                r_ex_ready;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic [31:0]         r_dmem_wdata;
    logic [3:0]          r_dmem_be;
    logic                r_wb_valid;
    logic [4:0]          r_wb_rd_addr;
    logic                r_wb_rd_we;
    logic [31:0]         r_wb_rd_data;
    logic                r_wb_exc;
    logic [3:0]          r_wb_exc_cause;
    logic [31:0]         r_wb_exc_tval;
    logic [4:0]          r_rd_addr;
    logic                r_rd_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_addr_lo;
    logic                r_is_load;

    logic [1:0]          w_off;
    logic                w_is_mem;
    logic                w_illegal;
    logic                w_misaligned;
    logic                w_exc;
    logic [3:0]          w_cause;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;

    assign w_off = i_ex_alu_result[1:0];

    // Decode the presented instruction: legality, alignment, store lanes
    always_comb begin
        w_is_mem     = i_ex_is_load | i_ex_is_store;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b0000;
        w_wdata      = 32'h0;
        if (i_ex_is_load) begin
            w_illegal = (i_ex_funct3 == 3'b011) | (i_ex_funct3[2:1] == 2'b11);
        end else if (i_ex_is_store) begin
            w_illegal = i_ex_funct3[2] | (i_ex_funct3[1:0] == 2'b11);
        end
        case (i_ex_funct3[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = |w_off;
            default: w_misaligned = 1'b0;
        endcase
        w_exc   = w_is_mem & (w_illegal | w_misaligned);
        w_cause = w_illegal ? 4'd2 : (i_ex_is_load ? 4'd4 : 4'd6);
        if (i_ex_is_store) begin
            case (i_ex_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{i_ex_store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{i_ex_store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_ex_store_data;
                end
            endcase
        end
    end

    // Lane-select and extend returning load data using the captured op
    always_comb begin
        w_load_data = i_dmem_rdata;
        case (r_addr_lo)
            2'd0:    w_byte = i_dmem_rdata[7:0];
            2'd1:    w_byte = i_dmem_rdata[15:8];
            2'd2:    w_byte = i_dmem_rdata[23:16];
            default: w_byte = i_dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_ex_ready     <= 1'b1;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= 32'h0;
            r_dmem_be      <= 4'b0000;
            r_wb_valid     <= 1'b0;
            r_wb_rd_addr   <= 5'd0;
            r_wb_rd_we     <= 1'b0;
            r_wb_rd_data   <= 32'h0;
            r_wb_exc       <= 1'b0;
            r_wb_exc_cause <= 4'd0;
            r_wb_exc_tval  <= 32'h0;
            r_rd_addr      <= 5'd0;
            r_rd_we        <= 1'b0;
            r_funct3       <= 3'd0;
            r_addr_lo      <= 2'd0;
            r_is_load      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ex_valid) begin
                        r_rd_addr <= i_ex_rd_addr;
                        r_rd_we   <= i_ex_rd_we;
                        r_funct3  <= i_ex_funct3;
                        r_addr_lo <= w_off;
                        r_is_load <= i_ex_is_load;
                        if (!w_is_mem) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_rd_addr   <= i_ex_rd_addr;
                            r_wb_rd_we     <= i_ex_rd_we & (i_ex_rd_addr != 5'd0);
                            r_wb_rd_data   <= i_ex_alu_result;
                            r_wb_exc       <= 1'b0;
                            r_wb_exc_cause <= 4'd0;
                            r_wb_exc_tval  <= 32'h0;
                        end else if (w_exc) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_rd_addr   <= i_ex_rd_addr;
                            r_wb_rd_we     <= 1'b0;
                            r_wb_rd_data   <= 32'h0;
                            r_wb_exc       <= 1'b1;
                            r_wb_exc_cause <= w_cause;
                            r_wb_exc_tval  <= i_ex_alu_result;
                        end else begin
                            r_state      <= S_BUS;
                            r_ex_ready   <= 1'b0;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= i_ex_is_store;
                            r_dmem_addr  <= {i_ex_alu_result[ADDR_W-1:2], 2'b00};
                            r_dmem_wdata <= w_wdata;
                            r_dmem_be    <= w_be;
                        end
                    end
                end
                S_BUS: begin
                    // Bus fields stay frozen until the ack edge
                    if (i_dmem_ack) begin
                        r_state        <= S_IDLE;
                        r_ex_ready     <= 1'b1;
                        r_dmem_req     <= 1'b0;
                        r_dmem_we      <= 1'b0;
                        r_dmem_be      <= 4'b0000;
                        r_wb_valid     <= 1'b1;
                        r_wb_rd_addr   <= r_rd_addr;
                        r_wb_rd_we     <= r_is_load & r_rd_we & (r_rd_addr != 5'd0);
                        r_wb_rd_data   <= r_is_load ? w_load_data : 32'h0;
                        r_wb_exc       <= 1'b0;
                        r_wb_exc_cause <= 4'd0;
                        r_wb_exc_tval  <= 32'h0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ex_ready     = r_ex_ready;
    assign o_dmem_req     = r_dmem_req;
    assign o_dmem_we      = r_dmem_we;
    assign o_dmem_addr    = r_dmem_addr;
    assign o_dmem_wdata   = r_dmem_wdata;
    assign o_dmem_be      = r_dmem_be;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd_addr   = r_wb_rd_addr;
    assign o_wb_rd_we     = r_wb_rd_we;
    assign o_wb_rd_data   = r_wb_rd_data;
    assign o_wb_exc       = r_wb_exc;
    assign o_wb_exc_cause = r_wb_exc_cause;
    assign o_wb_exc_tval  = r_wb_exc_tval;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus randomized ops against a
// behavioural model of load/store semantics.
module tb_memory_access;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [31:0]       ex_alu;
    logic [31:0]       ex_sd;
    logic [4:0]        ex_rd;
    logic              ex_we;
    logic              ex_ld;
    logic              ex_st;
    logic [2:0]        ex_f3;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              wb_we;
    logic [31:0]       wb_data;
    logic              wb_exc;
    logic [3:0]        wb_cause;
    logic [31:0]       wb_tval;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_access #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
        .i_ex_alu_result(ex_alu), .i_ex_store_data(ex_sd),
        .i_ex_rd_addr(ex_rd), .i_ex_rd_we(ex_we),
        .i_ex_is_load(ex_ld), .i_ex_is_store(ex_st), .i_ex_funct3(ex_f3),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
        .o_wb_valid(wb_valid), .o_wb_rd_addr(wb_rd), .o_wb_rd_we(wb_we),
        .o_wb_rd_data(wb_data), .o_wb_exc(wb_exc),
        .o_wb_exc_cause(wb_cause), .o_wb_exc_tval(wb_tval)
    );

    // Reference semantics of one instruction, from the ISA rules
    function automatic void model(
        input  logic ld, input logic st, input logic [2:0] f3,
        input  logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
        input  logic [4:0] rd, input logic we,
        output logic m_bus, output logic m_exc, output logic [3:0] m_cause,
        output logic [31:0] m_baddr, output logic [3:0] m_be,
        output logic [31:0] m_wdata, output logic [31:0] m_data, output logic m_rdwe);
        int          size;
        int          off;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] v;
        m_bus = 1'b0; m_exc = 1'b0; m_cause = 4'd0; m_baddr = 32'h0;
        m_be = 4'd0; m_wdata = 32'h0; m_data = 32'h0; m_rdwe = 1'b0;
        off = int'(a % 32'd4);
        if (!ld && !st) begin
            m_data = a;
            m_rdwe = we && (rd != 5'd0);
            return;
        end
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if (!legal) begin
            m_exc = 1'b1; m_cause = 4'd2;
            return;
        end
        if (off % size != 0) begin
            m_exc = 1'b1; m_cause = ld ? 4'd4 : 4'd6;
            return;
        end
        m_bus   = 1'b1;
        m_baddr = a - 32'(off);
        if (st) begin
            m_be    = (size == 4) ? 4'hF : 4'(((size == 1) ? 1 : 3) << off);
            m_wdata = (size == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
                      (size == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            v    = (rdat >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            m_data = v;
            m_rdwe = we && (rd != 5'd0);
        end
    endfunction

    // Issue one instruction, serve the bus after nreq request cycles, check everything
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic we, input int nreq, input logic [31:0] rdat, input string tag);
        logic m_bus, m_exc, m_rdwe;
        logic [3:0] m_cause, m_be;
        logic [31:0] m_baddr, m_wdata, m_data;
        model(ld, st, f3, a, sd, rdat, rd, we, m_bus, m_exc, m_cause, m_baddr, m_be, m_wdata, m_data, m_rdwe);
        @(negedge clk);
        ex_valid = 1'b1; ex_ld = ld; ex_st = st; ex_f3 = f3;
        ex_alu = a; ex_sd = sd; ex_rd = rd; ex_we = we;
        n_vec++;
        if (ex_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_at_issue: got %0b want 1", tag, ex_ready);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        if (!m_bus) begin
            n_vec++;
            if ({wb_valid, wb_exc, wb_we, dmem_req} !== {1'b1, m_exc, m_rdwe, 1'b0}) begin
                n_err++; $display("FAIL %s retire_flags: got v/exc/we/req=%b%b%b%b want %b%b%b0",
                                  tag, wb_valid, wb_exc, wb_we, dmem_req, 1'b1, m_exc, m_rdwe);
            end
            n_vec++;
            if (m_exc && {wb_cause, wb_tval} !== {m_cause, a}) begin
                n_err++; $display("FAIL %s exc_info: got cause=%0d tval=%h want cause=%0d tval=%h",
                                  tag, wb_cause, wb_tval, m_cause, a);
            end else if (!m_exc && {wb_rd, wb_data} !== {rd, m_data}) begin
                n_err++; $display("FAIL %s alu_result: got rd=%0d data=%h want rd=%0d data=%h",
                                  tag, wb_rd, wb_data, rd, m_data);
            end
        end else begin
            for (int i = 1; i <= nreq; i++) begin
                n_vec++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be, wb_valid, ex_ready} !==
                    {1'b1, st, m_baddr, m_be, 1'b0, 1'b0}) begin
                    n_err++; $display("FAIL %s bus_cycle%0d: got req=%b we=%b addr=%h be=%b wbv=%b rdy=%b want 1 %b %h %b 0 0",
                                      tag, i, dmem_req, dmem_we, dmem_addr, dmem_be, wb_valid, ex_ready, st, m_baddr, m_be);
                end
                if (st) begin
                    n_vec++;
                    if (dmem_wdata !== m_wdata) begin
                        n_err++; $display("FAIL %s wdata_cycle%0d: got %h want %h", tag, i, dmem_wdata, m_wdata);
                    end
                end
                // Offer a different op while busy; it must be ignored
                if (i < nreq) begin
                    ex_valid = 1'b1; ex_ld = 1'b0; ex_st = 1'b0; ex_alu = $urandom; ex_rd = 5'd7;
                end else begin
                    ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = rdat;
                end
                @(negedge clk);
                ex_valid = 1'b0;
            end
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            n_vec++;
            if ({wb_valid, wb_exc, wb_we, wb_rd, ex_ready, dmem_req} !== {1'b1, 1'b0, m_rdwe, rd, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL %s mem_retire: got v/exc/we=%b%b%b rd=%0d rdy=%b req=%b want 10%b rd=%0d rdy=1 req=0",
                                  tag, wb_valid, wb_exc, wb_we, wb_rd, ex_ready, dmem_req, m_rdwe, rd);
            end
            if (ld) begin
                n_vec++;
                if (wb_data !== m_data) begin
                    n_err++; $display("FAIL %s load_data: got %h want %h", tag, wb_data, m_data);
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL %s valid_pulse: got %b want 0", tag, wb_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_f3 = 3'd0;
        ex_alu = 32'h0; ex_sd = 32'h0; ex_rd = 5'd0; ex_we = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_rd, wb_we,
             wb_data, wb_exc, wb_cause, wb_tval} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
             5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0}) begin
            n_err++; $display("FAIL reset_state: got rdy=%b req=%b wbv=%b data=%h exc=%b want rdy=1 others 0",
                              ex_ready, dmem_req, wb_valid, wb_data, wb_exc);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        run_op(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1, 32'h0, "alu_pass");
        run_op(1'b0, 1'b0, 3'd2, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1, 32'h0, "alu_rd0");
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_vec++;
                if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 5'(i + 10), vals[i-1]}) begin
                    n_err++; $display("FAIL b2b_%0d: got v=%b we=%b rd=%0d data=%h want 1 1 %0d %h",
                                      i - 1, wb_valid, wb_we, wb_rd, wb_data, i + 10, vals[i-1]);
                end
            end
            if (i < 3) begin
                ex_valid = 1'b1; ex_ld = 1'b0; ex_st = 1'b0; ex_alu = vals[i];
                ex_rd = 5'(i + 11); ex_we = 1'b1;
            end else begin
                ex_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++;
        if (wb_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got v=%b want 0", wb_valid);
        end
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd9, 1'b1, 3, 32'h0, "sb_1003");
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'hCAFE_BEEF, 5'd9, 1'b1, 2, 32'h0, "sh_1002");
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_1004, 32'h0BAD_F00D, 5'd9, 1'b1, 1, 32'h0, "sw_1004");
    endtask

    task automatic test_loads();
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'h0, 5'd3, 1'b1, 1, 32'h0080_0000, "lb_2002");
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 5'd3, 1'b1, 1, 32'h0080_0000, "lbu_2002");
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0, 5'd3, 1'b1, 1, 32'h0080_0000, "lh_2002");
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 5'd0, 1'b1, 1, 32'h0080_0000, "lw_rd0");
    endtask

    task automatic test_exceptions();
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_3002, 32'h0, 5'd4, 1'b1, 1, 32'h0, "lw_misalign");
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_3001, 32'h0, 5'd4, 1'b1, 1, 32'h0, "sh_misalign");
        run_op(1'b1, 1'b0, 3'd3, 32'h0000_3000, 32'h0, 5'd4, 1'b1, 1, 32'h0, "ld_illegal");
        run_op(1'b0, 1'b1, 3'd4, 32'h0000_3000, 32'h0, 5'd4, 1'b1, 1, 32'h0, "st_illegal");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ex_valid = 1'b1; ex_ld = 1'b1; ex_st = 1'b0; ex_f3 = 3'd2; ex_alu = 32'h0000_4000;
        ex_rd = 5'd6; ex_we = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        n_vec++;
        if (dmem_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_req_up: got %b want 1", dmem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({dmem_req, ex_ready, wb_valid} !== 3'b010) begin
            n_err++; $display("FAIL rstmid_after: got req/rdy/wbv=%b%b%b want 010", dmem_req, ex_ready, wb_valid);
        end
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            n_vec++;
            if ({wb_valid, dmem_req, ex_ready} !== 3'b001) begin
                n_err++; $display("FAIL rstmid_late_ack%0d: got wbv/req/rdy=%b%b%b want 001",
                                  i, wb_valid, dmem_req, ex_ready);
            end
        end
        run_op(1'b0, 1'b0, 3'd0, 32'h0000_0042, 32'h0, 5'd8, 1'b1, 1, 32'h0, "rstmid_alu");
    endtask

    task automatic test_random();
        logic [2:0] f3;
        int         kind;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            f3   = 3'($urandom);
            if (kind == 1 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            run_op(kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)), $urandom, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_loads();
        test_exceptions();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access pipeline stage of the RV32I_Zicsr core, directly upstream of `write_back`. It accepts one instruction at a time from execute and performs aligned loads and stores on a single-port data-memory bus with a request/acknowledge handshake. It byte-lanes and sign- or zero-extends load data, and flags misaligned or illegal accesses as exceptions. It presents a registered, one-cycle-valid result to write-back.

## Interface
- `ADDR_W`, default 32: data-memory byte-address width.
- `i_clk`  in  1  CPU clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_ex_valid`  in  1  execute presents an instruction.
- `o_ex_ready`  out  1  stage can accept; high only in IDLE.
- `i_ex_alu_result`  in  32  ALU result, or effective address for load/store.
- `i_ex_store_data`  in  32  rs2 value for stores.
- `i_ex_rd_addr`  in  5  destination register.
- `i_ex_rd_we`  in  1  instruction writes rd.
- `i_ex_is_load` / `i_ex_is_store`  in  1 each  memory-op class; never both high.
- `i_ex_funct3`  in  3  RV32I width/sign code.
- `o_dmem_req`  out  1  bus request; held until ack.
- `o_dmem_we`  out  1  1 = store.
- `o_dmem_addr`  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- `o_dmem_wdata`  out  32  lane-replicated store data.
- `o_dmem_be`  out  4  byte enables; 0000 for loads.
- `i_dmem_ack`  in  1  completion; valid only while `o_dmem_req` is high.
- `i_dmem_rdata`  in  32  full word, valid with ack on loads.
- `o_wb_valid`  out  1  one-cycle pulse per retired instruction.
- `o_wb_rd_addr`  out  5  destination register.
- `o_wb_rd_we`  out  1  write enable.
- `o_wb_rd_data`  out  32  write-back data.
- `o_wb_exc`  out  1  exception flag.
- `o_wb_exc_cause`  out  4  mcause code.
- `o_wb_exc_tval`  out  32  faulting address.

## Operation
- FSM states: IDLE and BUS. Accept when `i_ex_valid & o_ex_ready`. Inputs are captured into internal registers at accept.
- IDLE transitions:
  - Non-memory op: stays IDLE. Next cycle: `o_wb_valid`=1, `o_wb_rd_data`=alu_result.
  - Aligned, legal memory op: goes to BUS and drives the `o_dmem_*` registers.
  - Misaligned or illegal op: stays IDLE. No bus request. Next cycle: `o_wb_valid`=1, `o_wb_exc`=1, `o_wb_rd_we`=0, `o_wb_exc_tval`=address.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0. Cause 4 for loads, 6 for stores.
- Illegal funct3 gives cause 2:
  - loads: 011, 110, 111;
  - stores: anything other than 000, 001, 010.
- BUS → IDLE on the `i_dmem_ack` edge. The result registers are loaded and `o_wb_valid` pulses the following cycle.
- Stores:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
  - Retire with `o_wb_rd_we`=0.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]. Sign-extend LB/LH, zero-extend LBU/LHU. LW passes the word.
- `o_wb_rd_we` = captured rd_we & (rd_addr≠0) & ~exc.
- `i_ex_valid` while `o_ex_ready`=0 is ignored; upstream holds its inputs.
- `i_dmem_ack` in IDLE is ignored.

## Timing
- Reset: on the `i_rst` edge, state=IDLE and every output register is cleared. After reset, `o_ex_ready`=1 and all other outputs are 0.
- Reset mid-BUS abandons the access: `o_dmem_req` is low the cycle after reset, no `o_wb_valid`, and a late ack is dropped.
- Non-memory and exception latency: accept at cycle N, `o_wb_valid` at N+1. Back-to-back accepts give one result per cycle.
- Memory latency:
  - accept at N;
  - `o_dmem_req` high from N+1;
  - first ack at cycle K (K ≥ N+1);
  - `o_wb_valid` at K+1;
  - `o_ex_ready` high again at K+1.
- Minimum memory latency is 2 cycles.
- `o_dmem_*` are stable from the req rise through the ack cycle. All outputs are registered.
- `o_wb_*` data fields hold their value until the next pulse; only `o_wb_valid` is a pulse.

## Test plan
- ALU passthrough:
  - Stimulus: alu_result=0x1234_5678, rd=5, rd_we=1, no memory op.
  - Response: one cycle later `o_wb_valid`=1, rd_data=0x12345678, rd_we=1. Three back-to-back instructions retire on three consecutive cycles.
- SB to 0x1003, rs2=0x0000_00AB, ack 3 cycles after req:
  - Bus: addr=0x1000, be=1000, wdata=0xABABABAB, we=1, held for all 3 cycles.
  - Result: `o_wb_valid` the cycle after ack with rd_we=0.
- Loads from address 0x2002 with rdata=0x0080_0000, ack in the first req cycle:
  - LB → 0xFFFFFF80; LBU → 0x00000080; LH from 0x2002 → 0x00000080.
  - rd=0 load → rd_we=0.
- Misaligned and illegal:
  - LW at 0x3002 → no req; next cycle exc=1, cause=4, tval=0x3002.
  - SH at 0x3001 → cause=6.
  - Load funct3=011 → cause=2.
- Reset mid-transaction:
  - Stimulus: assert `i_rst` with req outstanding, then ack arrives 2 cycles after reset release.
  - Response: req low the cycle after reset, no `o_wb_valid`, late ack ignored. `o_ex_ready`=1, and the next accepted ALU op retires normally.
